// File: rtl/seq_recogniser_param.sv
// Runtime-programmable serial pattern recogniser, 1..MAX_LEN bits.
// Define SEQREC_COUNT_EN to build the saturating matchCount register.
module seq_recogniser_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                         clock,
  input  logic                         nReset,
  input  logic                         load,
  input  logic [MAX_LEN-1:0]           patternIn,
  input  logic [$clog2(MAX_LEN+1)-1:0] lenIn,
  input  logic                         overlap,
  input  logic                         valid,
  input  logic                         dataIn,
  output logic                         matchAll,
  output logic                         armed,
  output logic [CNT_W-1:0]             matchCount
);

  localparam int LW = $clog2(MAX_LEN+1);

  typedef enum logic {UNLOADED, RUN} state_t;

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pat;
  logic [LW-1:0]      r_len;
  // Oldest history bit can never reach a len<=MAX_LEN candidate.
  logic [MAX_LEN-2:0] r_hist;
  logic [LW-1:0]      r_fill;
  logic               r_match;

  logic [MAX_LEN-1:0] w_mask;
  logic [MAX_LEN-1:0] w_cand;
  logic [LW:0]        w_fill1;
  logic               w_legal;
  logic               w_hit;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      w_mask[i] = (i < int'(r_len));
  end

  assign w_cand  = {r_hist, dataIn} & w_mask;
  assign w_fill1 = {1'b0, r_fill} + (LW+1)'(1);
  assign w_legal = (lenIn != '0) &&
                   (lenIn <= LW'(MAX_LEN));
  assign w_hit   = (r_state == RUN) && valid &&
                   !load &&
                   (w_fill1 >= {1'b0, r_len}) &&
                   (w_cand == (r_pat & w_mask));

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= UNLOADED;
      r_pat   <= '0;
      r_len   <= '0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (load) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
      if (w_legal) begin
        r_state <= RUN;
        r_pat   <= patternIn;
        r_len   <= lenIn;
      end else begin
        r_state <= UNLOADED;
        r_pat   <= '0;
        r_len   <= '0;
      end
    end else if (r_state == RUN && valid) begin
      r_hist  <= w_cand[MAX_LEN-2:0] |
                 ({r_hist, dataIn} & ~w_mask)
                 ;
      r_match <= w_hit;
      if (w_hit && !overlap)
        r_fill <= '0;
      else if (r_fill != LW'(MAX_LEN))
        r_fill <= r_fill + LW'(1);
    end else begin
      r_match <= 1'b0;
    end
  end

  assign matchAll = r_match;
  assign armed    = (r_state == RUN);

`ifdef SEQREC_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset)
      r_cnt <= '0;
    else if (load)
      r_cnt <= '0;
    else if (w_hit && r_cnt != '1)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign matchCount = r_cnt;
`else
  assign matchCount = '0;
`endif

endmodule

// File: tb/tb_seq_recogniser_param.sv
// Directed bench for seq_recogniser_param (MAX_LEN=8, CNT_W=2).
// Expected counts follow SEQREC_COUNT_EN; zero when undefined.
module tb_seq_recogniser_param;

`ifdef SEQREC_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       nReset;
  logic       load;
  logic [7:0] patternIn;
  logic [3:0] lenIn;
  logic       overlap;
  logic       valid;
  logic       dataIn;
  logic       matchAll;
  logic       armed;
  logic [1:0] matchCount;

  int nvec = 0;
  int nerr = 0;

  seq_recogniser_param #(.MAX_LEN(8), .CNT_W(2)) dut (
    .clock      (clock),
    .nReset     (nReset),
    .load       (load),
    .patternIn  (patternIn),
    .lenIn      (lenIn),
    .overlap    (overlap),
    .valid      (valid),
    .dataIn     (dataIn),
    .matchAll   (matchAll),
    .armed      (armed),
    .matchCount (matchCount)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ec(input int n);
    int s;
    s = (n > 3) ? 3 : n;
    return CNT_EN ? 32'(s) : 32'd0;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [7:0] p,
                         input logic [3:0] l,
                         input logic v,
                         input logic d);
    load = 1'b1; patternIn = p; lenIn = l;
    valid = v; dataIn = d;
    tick();
    load = 1'b0; valid = 1'b0;
  endtask

  // Bits sent MSB first; em[i] is the pulse expected after bits[i].
  task automatic send(input logic [31:0] bits,
                      input int n,
                      input logic [31:0] em,
                      input bit gaps,
                      input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          valid = 1'b0; dataIn = $urandom_range(0, 1);
          tick();
          chk({tag, "_gap"}, 32'(matchAll), 32'd0);
        end
      end
      valid = 1'b1; dataIn = bits[i];
      tick();
      chk($sformatf("%s_b%0d", tag, n - i),
          32'(matchAll), 32'(em[i]));
      valid = 1'b0;
    end
  endtask

  initial begin
    nReset = 1'b0; load = 1'b0; patternIn = '0;
    lenIn = '0; overlap = 1'b1; valid = 1'b0;
    dataIn = 1'b0;
    #2;
    chk("rst_match", 32'(matchAll), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_count", 32'(matchCount), 32'd0);
    tick();
    nReset = 1'b1;
    tick();

    send(32'b1011, 4, 32'b0000, 1'b0, "unloaded");
    chk("unloaded_armed", 32'(armed), 32'd0);

    overlap = 1'b1;
    do_load(8'b10110110, 4'd8, 1'b0, 1'b0);
    chk("ov_armed", 32'(armed), 32'd1);
    send(32'b10110110110110, 14,
         32'b00000001001001, 1'b0, "ov");
    chk("ov_count", 32'(matchCount), ec(3));

    overlap = 1'b0;
    do_load(8'b10110110, 4'd8, 1'b0, 1'b0);
    chk("nov_count0", 32'(matchCount), 32'd0);
    send(32'b10110110110110, 14,
         32'b00000001000000, 1'b0, "nov");
    chk("nov_count", 32'(matchCount), ec(1));

    overlap = 1'b1;
    do_load(8'b10110110, 4'd8, 1'b0, 1'b0);
    send(32'b10110110110110, 14,
         32'b00000001001001, 1'b1, "gap");
    chk("gap_count", 32'(matchCount), ec(3));

    do_load(8'b00000001, 4'd1, 1'b0, 1'b0);
    send(32'b1101, 4, 32'b1101, 1'b0, "len1");
    chk("len1_count", 32'(matchCount), ec(3));

    do_load(8'b00000000, 4'd0, 1'b0, 1'b0);
    chk("len0_armed", 32'(armed), 32'd0);
    chk("len0_count", 32'(matchCount), 32'd0);
    send(32'b00001111, 8, 32'b0, 1'b0, "len0");

    do_load(8'b11111111, 4'd9, 1'b0, 1'b0);
    chk("len9_armed", 32'(armed), 32'd0);
    send(32'b1111, 4, 32'b0, 1'b0, "len9");

    do_load(8'b00000001, 4'd1, 1'b1, 1'b1);
    chk("ldv_match", 32'(matchAll), 32'd0);
    chk("ldv_armed", 32'(armed), 32'd1);

    do_load(8'b10110110, 4'd8, 1'b0, 1'b0);
    send(32'b1011011, 7, 32'b0, 1'b0, "pre");
    do_load(8'b00000111, 4'd3, 1'b0, 1'b0);
    chk("rl_armed", 32'(armed), 32'd1);
    chk("rl_count0", 32'(matchCount), 32'd0);
    send(32'b0111, 4, 32'b0001, 1'b0, "rl");
    chk("rl_count", 32'(matchCount), ec(1));

    do_load(8'b00000001, 4'd1, 1'b0, 1'b0);
    send(32'b11111, 5, 32'b11111, 1'b0, "sat");
    chk("sat_count", 32'(matchCount), ec(5));

    do_load(8'b00000001, 4'd1, 1'b0, 1'b0);
    send(32'b11, 2, 32'b11, 1'b0, "prer");
    #2;
    nReset = 1'b0;
    #1;
    chk("arst_match", 32'(matchAll), 32'd0);
    chk("arst_armed", 32'(armed), 32'd0);
    chk("arst_count", 32'(matchCount), 32'd0);
    tick();
    nReset = 1'b1;
    send(32'b11, 2, 32'b00, 1'b0, "post");

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
